// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and controller state encoding
// shared by the iterative compression core.
package sha256_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_e;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] Sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h in, a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [0:7][31:0] st_i,
  input  logic [31:0]      k_i,
  input  logic [31:0]      w_i,
  output logic [0:7][31:0] st_o
);

  logic [31:0] t1, t2;

  always_comb begin
    t1 = st_i[7] + Sig1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    t2 = Sig0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
    st_o[0] = t1 + t2;
    st_o[1] = st_i[0];
    st_o[2] = st_i[1];
    st_o[3] = st_i[2];
    st_o[4] = st_i[3] + t1;
    st_o[5] = st_i[4];
    st_o[6] = st_i[5];
    st_o[7] = st_i[6];
  end

endmodule

// File: rtl/sha256_iter.sv
// Iterative multi-block SHA-256 core: UNROLL rounds per clock, chaining
// value kept across blocks, digest published after the block marked last.
module sha256_iter
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [0:511] blk,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         busy,
  output logic         hash_valid,
  output logic [0:255] hash
);

  state_e            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [0:15][31:0] w_q, w_d, w_shift;
  logic [0:7][31:0]  st_q, st_d, h_q, h_d;
  logic [0:255]      hash_q, hash_d;
  logic              hash_valid_q, hash_valid_d;

  logic [0:7][31:0]  chain [0:UNROLL];
  logic [31:0]       ext   [0:15+UNROLL];

  assign chain[0] = st_q;

  for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
    sha256_round u_round (
      .st_i (chain[u]),
      .k_i  (K[cnt_q[5:0] + 6'(u)]),
      .w_i  (w_q[u]),
      .st_o (chain[u+1])
    );
  end

  // Window holds W[cnt..cnt+15]; extend by UNROLL words, then drop the oldest.
  for (genvar i = 0; i < 16; i++) begin : g_ext_cur
    assign ext[i] = w_q[i];
  end
  for (genvar i = 16; i < 16 + UNROLL; i++) begin : g_ext_new
    assign ext[i] = sig1(ext[i-2]) + ext[i-7] + sig0(ext[i-15]) + ext[i-16];
  end
  for (genvar i = 0; i < 16; i++) begin : g_shift
    assign w_shift[i] = ext[i+UNROLL];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    w_d          = w_q;
    st_d         = st_q;
    h_d          = h_q;
    hash_d       = hash_q;
    hash_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (blk_valid) begin
          w_d    = blk;
          last_d = blk_last;
          cnt_d  = '0;
          if (blk_first) begin
            st_d = IV;
            h_d  = IV;
          end else begin
            st_d = h_q;
          end
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        st_d  = chain[UNROLL];
        w_d   = w_shift;
        cnt_d = cnt_q + 7'(UNROLL);
        if (cnt_q == 7'(64 - UNROLL)) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + st_q[i];
        if (last_q) begin
          hash_d       = h_d;
          hash_valid_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      w_q          <= '0;
      st_q         <= '0;
      h_q          <= IV;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      w_q          <= w_d;
      st_q         <= st_d;
      h_q          <= h_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
    end
  end

  assign blk_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign hash_valid = hash_valid_q;
  assign hash       = hash_q;

endmodule

// File: tb/tb_sha256_iter.sv
// Directed-vector bench for sha256_iter; five instances cover every UNROLL.
module tb_sha256_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid;
  logic [0:511] blk;
  logic         blk_first, blk_last;
  logic [4:0]   rdy, bsy, hv;
  logic [0:255] hs [5];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  localparam logic [0:511] ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [0:511] EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [0:511] TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [0:511] TWO2  = {{15{32'h0}}, 32'h000001c0};

  localparam logic [0:255] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [0:255] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [0:255] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sha256_iter #(.UNROLL(1 << g)) dut (
      .clk        (clk),
      .reset      (reset),
      .blk_valid  (blk_valid),
      .blk_ready  (rdy[g]),
      .blk        (blk),
      .blk_first  (blk_first),
      .blk_last   (blk_last),
      .busy       (bsy[g]),
      .hash_valid (hv[g]),
      .hash       (hs[g])
    );
  end

  // Present a block on instance 0 once ready; acc = cycle count of the accept edge.
  task automatic send(input logic [0:511] b, input logic f, input logic l, output int acc);
    int n = 0;
    @(negedge clk);
    while (!rdy[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[0]) begin
      checks++; failures++;
      $display("FAIL send_ready: blk_ready=%b required 1 within 200 cycles", rdy[0]);
    end
    blk_valid = 1'b1; blk = b; blk_first = f; blk_last = l;
    @(posedge clk); #1;
    acc = cyc;
    blk_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int acc, input int span, output int lat,
                            output logic [0:255] h, output int pulses);
    lat = -1; h = '0; pulses = 0;
    for (int i = 0; i < span; i++) begin
      @(negedge clk);
      if (hv[0]) begin
        if (pulses == 0) begin
          lat = cyc - acc;
          h   = hs[0];
        end
        pulses++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy[0] !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", rdy[0]); end
    checks++; if (bsy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bsy[0]); end
    checks++; if (hv[0] !== 1'b0) begin failures++; $display("FAIL reset_hash_valid: got %b want 0", hv[0]); end
    checks++; if (hs[0] !== 256'h0) begin failures++; $display("FAIL reset_hash: got %h want 0", hs[0]); end
    reset = 1'b0;
  endtask

  task automatic test_empty_all();
    int acc;
    int lat [5];
    logic [0:255] h [5];
    for (int g = 0; g < 5; g++) begin lat[g] = -1; h[g] = '0; end
    send(EMPTY, 1'b1, 1'b1, acc);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++)
        if (hv[g] && lat[g] < 0) begin
          lat[g] = cyc - acc;
          h[g]   = hs[g];
        end
    end
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (h[g] !== EMPTY_D) begin failures++; $display("FAIL empty_hash_u%0d: got %h want %h", 1 << g, h[g], EMPTY_D); end
      checks++;
      if (lat[g] != 64 / (1 << g) + 1) begin
        failures++; $display("FAIL empty_latency_u%0d: got %0d want %0d", 1 << g, lat[g], 64 / (1 << g) + 1);
      end
    end
  endtask

  task automatic test_abc();
    int acc, lat, p;
    logic [0:255] h;
    send(ABC, 1'b1, 1'b1, acc);
    wait_pulse(acc, 90, lat, h, p);
    checks++; if (h !== ABC_D) begin failures++; $display("FAIL abc_hash: got %h want %h", h, ABC_D); end
    checks++; if (lat != 65) begin failures++; $display("FAIL abc_latency: got %0d want 65", lat); end
    checks++; if (p != 1) begin failures++; $display("FAIL abc_pulses: got %0d want 1", p); end
  endtask

  task automatic test_two_block();
    int acc, lat, p;
    logic [0:255] h;
    send(TWO1, 1'b1, 1'b0, acc);
    wait_pulse(acc, 70, lat, h, p);
    checks++; if (p != 0) begin failures++; $display("FAIL two_mid_pulse: got %0d pulses want 0", p); end
    checks++; if (hs[0] !== ABC_D) begin failures++; $display("FAIL two_mid_hold: got %h want %h", hs[0], ABC_D); end
    send(TWO2, 1'b0, 1'b1, acc);
    wait_pulse(acc, 70, lat, h, p);
    checks++; if (h !== TWO_D) begin failures++; $display("FAIL two_hash: got %h want %h", h, TWO_D); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, n, bad_hold, lat, p;
    logic [0:255] h1, h2;
    acc2 = -1; h1 = '0; bad_hold = 0;
    @(negedge clk);
    n = 0;
    while (!rdy[0] && n < 200) begin @(negedge clk); n++; end
    blk_valid = 1'b1; blk = ABC; blk_first = 1'b1; blk_last = 1'b1;
    @(posedge clk); #1;
    acc1 = cyc;
    blk = EMPTY;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hv[0]) h1 = hs[0];
      if (rdy[0]) begin
        acc2 = cyc + 1;
        @(posedge clk); #1;
        blk_valid = 1'b0;
        break;
      end
    end
    blk_valid = 1'b0;
    checks++; if (acc2 - acc1 != 66) begin failures++; $display("FAIL b2b_gap: got %0d want 66", acc2 - acc1); end
    checks++; if (h1 !== ABC_D) begin failures++; $display("FAIL b2b_hash1: got %h want %h", h1, ABC_D); end
    lat = -1; h2 = '0; p = 0;
    for (int i = 0; i < 80 && p == 0; i++) begin
      @(negedge clk);
      if (hv[0]) begin p = 1; h2 = hs[0]; lat = cyc - acc2; end
      else if (hs[0] !== ABC_D) bad_hold++;
    end
    checks++; if (bad_hold != 0) begin failures++; $display("FAIL b2b_hold: got %0d bad cycles want 0", bad_hold); end
    checks++; if (h2 !== EMPTY_D) begin failures++; $display("FAIL b2b_hash2: got %h want %h", h2, EMPTY_D); end
    checks++; if (lat != 65) begin failures++; $display("FAIL b2b_latency2: got %0d want 65", lat); end
  endtask

  task automatic test_garbage();
    int acc, lat, p;
    logic [0:255] h;
    send(ABC, 1'b1, 1'b1, acc);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      blk_valid = 1'($urandom_range(0, 1));
      blk       = {16{$urandom()}};
      blk_first = 1'($urandom_range(0, 1));
      blk_last  = 1'($urandom_range(0, 1));
    end
    blk_valid = 1'b0;
    wait_pulse(acc, 50, lat, h, p);
    checks++; if (h !== ABC_D) begin failures++; $display("FAIL garbage_hash: got %h want %h", h, ABC_D); end
    checks++; if (lat != 65) begin failures++; $display("FAIL garbage_latency: got %0d want 65", lat); end
    checks++; if (bsy[0] !== 1'b0) begin failures++; $display("FAIL garbage_busy: got %b want 0", bsy[0]); end
  endtask

  task automatic test_mid_reset();
    int acc, lat, p;
    logic [0:255] h;
    send(TWO1, 1'b1, 1'b0, acc);
    wait_pulse(acc, 70, lat, h, p);
    send(ABC, 1'b0, 1'b0, acc);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (hs[0] !== 256'h0) begin failures++; $display("FAIL midrst_hash: got %h want 0", hs[0]); end
    checks++; if (hv[0] !== 1'b0) begin failures++; $display("FAIL midrst_hash_valid: got %b want 0", hv[0]); end
    checks++; if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      failures++; $display("FAIL midrst_state: busy=%b ready=%b want busy=0 ready=1", bsy[0], rdy[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_pulse(acc, 70, lat, h, p);
    checks++; if (p != 0) begin failures++; $display("FAIL midrst_stray_pulse: got %0d want 0", p); end
    send(ABC, 1'b0, 1'b1, acc);
    wait_pulse(acc, 70, lat, h, p);
    checks++; if (h !== ABC_D) begin failures++; $display("FAIL midrst_chain_iv: got %h want %h", h, ABC_D); end
  endtask

  initial begin
    reset = 1'b1; blk_valid = 1'b0; blk = '0; blk_first = 1'b0; blk_last = 1'b0;
    test_reset();
    test_empty_all();
    test_abc();
    test_two_block();
    test_back_to_back();
    test_garbage();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_iter.md
# sha256_iter

Iterative, multi-block SHA-256 compression core. It replaces the fully unrolled single-block hasher with a sequential datapath that applies `UNROLL` rounds per clock. It chains any number of 512-bit blocks into one digest and accepts pre-padded blocks over a valid/ready handshake. It sits between a block source (padder, UART/host loader) and the digest consumer (hex printer, comparator).

## Interface

**Parameters**
- `UNROLL`, default 1: rounds per clock. Legal values: 1, 2, 4, 8, 16. `N = 64/UNROLL` is the number of round cycles per block.

**Ports**
- `clk`, in, 1: sole clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-high reset.
- `blk_valid`, in, 1: `blk`, `blk_first` and `blk_last` are valid.
- `blk_ready`, out, 1: core can accept a block.
- `blk`, in, [0:511]: pre-padded message block, big-endian; `blk[0:31]` is W0.
- `blk_first`, in, 1: start a new message; chaining value is loaded with the IV.
- `blk_last`, in, 1: the digest is published after this block.
- `busy`, out, 1: a block is in flight (state ≠ IDLE).
- `hash_valid`, out, 1: one-cycle pulse marking a new digest.
- `hash`, out, [0:255]: digest, H0 in `hash[0:31]`. Holds its value until the next digest is published.

## Operation
- **States:** IDLE, ROUND, FINAL.
- **IDLE:** `blk_ready=1`. A handshake (`blk_valid & blk_ready` at an edge):
  - Loads `blk` into a 16-word schedule window.
  - Loads a..h from the IV if `blk_first`, else from the chaining regs H.
  - Latches `blk_last`, clears the round counter, and goes to ROUND.
- **ROUND:**
  - Each edge applies `UNROLL` rounds using K[cnt..cnt+UNROLL-1].
  - The schedule window shifts by `UNROLL` words, computing W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] on the fly.
  - `cnt += UNROLL`. After the N-th ROUND edge, go to FINAL.
- **FINAL:**
  - Next edge: H_i ← H_i + {a..h}_i, modulo 2^32 per word.
  - If the latched last flag is set: `hash ← updated H`, `hash_valid ← 1`.
  - Go to IDLE.
- **Arithmetic:** all additions are 32-bit and wrap. ROTR is a right rotate within 32 bits.
- `blk_first` and `blk_last` may both be high (single-block message).
- `blk_first=0` on the first block after reset chains from the IV, because H resets to the IV.
- `blk_valid` while not ready is ignored. Inputs may change freely once the accept edge has passed.
- **Reset (any state, including mid-block):**
  - IDLE, `blk_ready=1`, `busy=0`, `hash_valid=0`, `hash=0`.
  - H = IV, a..h = 0, cnt = 0.
  - The in-flight block is discarded.

## Timing
- Accept edge E0. ROUND edges E1..EN. FINAL edge EN+1. `hash_valid` is high for the single cycle following EN+1.
- `blk_ready` is low from E0 until EN+1. The next accept is possible at edge EN+2.
- Throughput: one block per N+2 cycles (66 cycles at `UNROLL=1`, 6 cycles at `UNROLL=16`).
- `busy` is registered: high after E0, low after EN+1.
- Non-last blocks produce no `hash_valid`, and `hash` is unchanged.

## Structure
- **`sha256_pkg`:**
  - K[0:63] and IV[0:7] constants.
  - Functions `rotr`, `ch`, `maj`, `Sig0`, `Sig1`, `sig0`, `sig1`.
  - State enum.
- **`sha256_round`:** one combinational round (a..h, K, W in → a..h out), instantiated `UNROLL` times in a generate chain.
- The top holds the FSM, counter, schedule window, and H/hash registers.
- Target size: 200–350 lines.

## Test plan
1. **"abc", single block, `first=last=1`, `UNROLL=1`:** `hash=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad`, `hash_valid` exactly 65 cycles after the accept edge, a single pulse.
2. **Empty message (block `80000000…0`, length 0), every legal `UNROLL`:** `hash=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855`, latency N+1.
3. **Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"** (block 1 `first=1,last=0`; block 2 `first=0,last=1`): no pulse after block 1; final `hash=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1`.
4. **Back-to-back "abc" then empty message, `blk_valid` held high:** second accept occurs exactly N+2 cycles after the first; both digests are correct; `hash` holds the "abc" digest between the two pulses.
5. **Reset asserted mid-ROUND, then "abc" sent with `first=0,last=1`:** `hash=0` and `hash_valid=0` during reset; no pulse from the aborted block; then the "abc" digest, proving H was reset to the IV.
6. **`blk_valid` toggled with garbage while busy:** ignored; the in-flight digest is unchanged.
